// File: rtl/commit_unit.sv
// In-order retirement stage at the ROB head: retires register writes, hands stores to
// memory through a valid/ready handshake, and turns a retiring mispredict into a flush plus redirect.
module commit_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MCNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rob_empty,
    input  logic              head_ready,
    input  logic [1:0]        head_itype,
    input  logic [3:0]        head_rob_num,
    input  logic [4:0]        head_dest,
    input  logic [31:0]       head_value,
    input  logic [31:0]       head_addr,
    input  logic              head_branch_result,
    input  logic [31:0]       head_target,
    output logic              rd_en,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [3:0]        rf_wrob,
    output logic              st_valid,
    output logic [31:0]       st_addr,
    output logic [31:0]       st_data,
    input  logic              st_ready,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [31:0]       commit_count,
    output logic [MCNT_W-1:0] mispredict_count
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_STORE,
        S_FLUSH
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_st_valid;
    logic [31:0]       r_st_addr;
    logic [31:0]       r_st_data;
    logic              r_flush;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic [31:0]       r_commit_count;
    logic [MCNT_W-1:0] r_mispredict_count;

    logic w_commit;
    logic w_is_reg;
    logic w_is_store;
    logic w_is_branch;

    assign w_commit    = !rob_empty && head_ready;
    assign w_is_reg    = head_itype[1];
    assign w_is_store  = (head_itype == 2'b01);
    assign w_is_branch = (head_itype == 2'b00);

    // Retirement strobes are gated by reset so nothing retires while the unit is held in reset.
    always_comb begin
        rd_en    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_wrob  = '0;
        if (reset) begin
            case (r_state)
                S_RUN: begin
                    if (w_commit && w_is_reg) begin
                        rd_en    = 1'b1;
                        rf_we    = (head_dest != 5'd0);
                        rf_waddr = head_dest;
                        rf_wdata = head_value;
                        rf_wrob  = head_rob_num;
                    end else if (w_commit && w_is_branch) begin
                        rd_en = 1'b1;
                    end
                end
                S_STORE: rd_en = r_st_valid && st_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_RUN;
            r_cnt              <= '0;
            r_st_valid         <= 1'b0;
            r_st_addr          <= '0;
            r_st_data          <= '0;
            r_flush            <= 1'b0;
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_commit_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (rd_en) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
            case (r_state)
                S_RUN: begin
                    if (w_commit && w_is_store) begin
                        r_state    <= S_STORE;
                        r_st_valid <= 1'b1;
                        r_st_addr  <= head_addr;
                        r_st_data  <= head_value;
                    end else if (w_commit && w_is_branch && head_branch_result) begin
                        r_state            <= S_FLUSH;
                        r_flush            <= 1'b1;
                        r_cnt              <= CNT_INIT;
                        r_redirect_pc      <= head_target;
                        r_redirect_valid   <= (CNT_INIT == '0);
                        r_mispredict_count <= r_mispredict_count + MCNT_W'(1);
                    end
                end
                S_STORE: begin
                    if (st_ready) begin
                        r_state    <= S_RUN;
                        r_st_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // redirect_valid is set one edge early so it coincides with the counter reaching 0.
                    if (r_cnt == '0) begin
                        r_state          <= S_RUN;
                        r_flush          <= 1'b0;
                        r_redirect_valid <= 1'b0;
                    end else begin
                        r_cnt            <= r_cnt - CW'(1);
                        r_redirect_valid <= (r_cnt == CW'(1));
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign st_valid         = r_st_valid;
    assign st_addr          = r_st_addr;
    assign st_data          = r_st_data;
    assign flush            = r_flush;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign commit_count     = r_commit_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: ALU retirement, store handshake, mispredict flush,
// empty-ROB stalls, asynchronous reset mid-operation and commit counter wrap.
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rob_empty;
    logic        head_ready;
    logic [1:0]  head_itype;
    logic [3:0]  head_rob_num;
    logic [4:0]  head_dest;
    logic [31:0] head_value;
    logic [31:0] head_addr;
    logic        head_branch_result;
    logic [31:0] head_target;
    logic        rd_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_wrob;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] commit_count;
    logic [15:0] mispredict_count;

    int testsRun  = 0;
    int failCount = 0;

    commit_unit #(.FLUSH_CYCLES(2), .MCNT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .rob_empty          (rob_empty),
        .head_ready         (head_ready),
        .head_itype         (head_itype),
        .head_rob_num       (head_rob_num),
        .head_dest          (head_dest),
        .head_value         (head_value),
        .head_addr          (head_addr),
        .head_branch_result (head_branch_result),
        .head_target        (head_target),
        .rd_en              (rd_en),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .rf_wrob            (rf_wrob),
        .st_valid           (st_valid),
        .st_addr            (st_addr),
        .st_data            (st_data),
        .st_ready           (st_ready),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .commit_count       (commit_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic empty, input logic ready, input logic [1:0] itype,
                                 input logic [3:0] robNum, input logic [4:0] dest,
                                 input logic [31:0] value, input logic [31:0] addr,
                                 input logic br, input logic [31:0] target);
        rob_empty          = empty;
        head_ready         = ready;
        head_itype         = itype;
        head_rob_num       = robNum;
        head_dest          = dest;
        head_value         = value;
        head_addr          = addr;
        head_branch_result = br;
        head_target        = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset    = 1'b0;
        st_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        checkOutput("reset_rd_en", rd_en, 0);
        checkOutput("reset_st_valid", st_valid, 0);
        checkOutput("reset_flush", flush, 0);
        checkOutput("reset_commit_count", commit_count, 0);
        #10 reset = 1'b1;
        nextCycle();

        // Three back-to-back ALU retirements, the last one to x0
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd1, 5'd5, 32'h11, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alu0_rd_en", rd_en, 1);
        checkOutput("alu0_rf_we", rf_we, 1);
        checkOutput("alu0_waddr", rf_waddr, 5);
        checkOutput("alu0_wdata", rf_wdata, 32'h11);
        checkOutput("alu0_wrob", rf_wrob, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd2, 5'd6, 32'h22, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alu1_rd_en", rd_en, 1);
        checkOutput("alu1_waddr", rf_waddr, 6);
        checkOutput("alu1_wdata", rf_wdata, 32'h22);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd3, 5'd0, 32'h33, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("alu2_rd_en", rd_en, 1);
        checkOutput("alu2_rf_we_x0", rf_we, 0);
        nextCycle();
        rob_empty = 1'b1;
        #1;
        checkOutput("alu_commit_count", commit_count, 3);
        checkOutput("idle_rd_en", rd_en, 0);

        // Store with memory stalling for three cycles
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd4, 5'd0, 32'hDEAD, 32'h1000, 1'b0, 32'h0);
        #1;
        checkOutput("st_issue_rd_en", rd_en, 0);
        checkOutput("st_issue_valid", st_valid, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b01, 4'd4, 5'd0, 32'hBEEF, 32'h2000, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("st_wait_valid", st_valid, 1);
            checkOutput("st_wait_addr", st_addr, 32'h1000);
            checkOutput("st_wait_data", st_data, 32'hDEAD);
            checkOutput("st_wait_rd_en", rd_en, 0);
            nextCycle();
        end
        st_ready = 1'b1;
        #1;
        checkOutput("st_hs_valid", st_valid, 1);
        checkOutput("st_hs_addr", st_addr, 32'h1000);
        checkOutput("st_hs_rd_en", rd_en, 1);
        nextCycle();
        st_ready  = 1'b0;
        rob_empty = 1'b1;
        #1;
        checkOutput("st_done_valid", st_valid, 0);
        checkOutput("st_commit_count", commit_count, 4);

        // Mispredicted branch, then a ready ALU head that must wait out the flush
        applyStimulus(1'b0, 1'b1, 2'b00, 4'd5, 5'd0, 32'h0, 32'h0, 1'b1, 32'h400);
        #1;
        checkOutput("br_n_rd_en", rd_en, 1);
        checkOutput("br_n_flush", flush, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd6, 5'd7, 32'h77, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("br_n1_flush", flush, 1);
        checkOutput("br_n1_redirect", redirect_valid, 0);
        checkOutput("br_n1_rd_en", rd_en, 0);
        checkOutput("br_n1_rf_we", rf_we, 0);
        checkOutput("br_mcount", mispredict_count, 1);
        nextCycle();
        checkOutput("br_n2_flush", flush, 1);
        checkOutput("br_n2_redirect", redirect_valid, 1);
        checkOutput("br_n2_pc", redirect_pc, 32'h400);
        checkOutput("br_n2_rd_en", rd_en, 0);
        nextCycle();
        checkOutput("br_n3_flush", flush, 0);
        checkOutput("br_n3_redirect", redirect_valid, 0);
        checkOutput("br_n3_rd_en", rd_en, 1);
        checkOutput("br_n3_waddr", rf_waddr, 7);
        nextCycle();
        rob_empty = 1'b1;
        #1;
        checkOutput("br_commit_count", commit_count, 6);

        // Empty ROB with a stale ready head, every itype
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 2'(i), 4'd8, 5'd9, 32'h99, 32'h3000, 1'b1, 32'h800);
            #1;
            checkOutput("empty_rd_en", rd_en, 0);
            checkOutput("empty_rf_we", rf_we, 0);
            checkOutput("empty_st_valid", st_valid, 0);
            nextCycle();
        end
        checkOutput("empty_commit_count", commit_count, 6);
        checkOutput("empty_flush", flush, 0);

        // Asynchronous reset while a store is pending
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd9, 5'd0, 32'h5555, 32'h4000, 1'b0, 32'h0);
        nextCycle();
        checkOutput("rst_st_valid_pre", st_valid, 1);
        st_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_st_valid", st_valid, 0);
        checkOutput("rst_st_rd_en", rd_en, 0);
        checkOutput("rst_st_commit", commit_count, 0);
        rob_empty = 1'b1;
        st_ready  = 1'b0;
        #1 reset = 1'b1;
        nextCycle();
        checkOutput("rst_st_after_valid", st_valid, 0);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd10, 5'd3, 32'hA, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("rst_st_run_rd_en", rd_en, 1);
        nextCycle();

        // Asynchronous reset during the flush window
        applyStimulus(1'b0, 1'b1, 2'b00, 4'd11, 5'd0, 32'h0, 32'h0, 1'b1, 32'h900);
        nextCycle();
        checkOutput("rst_fl_flush_pre", flush, 1);
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_fl_flush", flush, 0);
        checkOutput("rst_fl_redirect_pc", redirect_pc, 0);
        checkOutput("rst_fl_mcount", mispredict_count, 0);
        checkOutput("rst_fl_commit", commit_count, 0);
        rob_empty = 1'b1;
        #1 reset = 1'b1;
        nextCycle();
        checkOutput("rst_fl_after_flush", flush, 0);
        checkOutput("rst_fl_after_redirect", redirect_valid, 0);

        // Commit counter wrap
        force dut.r_commit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_commit_count;
        #1;
        checkOutput("wrap_preload", commit_count, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd12, 5'd4, 32'hC, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("wrap_rd_en", rd_en, 1);
        nextCycle();
        rob_empty = 1'b1;
        #1;
        checkOutput("wrap_commit_count", commit_count, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
